keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad and debounces it. Presents one clean key event to the calculator core as a
//  level key_pressed plus a 4-bit code on keypad_out. Sits directly upstream of the calculator.
//  Key map (row,col) -> code: r0: 1 2 3 A(+) | r1: 4 5 6 B(-) | r2: 7 8 9 C(*) | r3: F(dp) 0 E(clr) D(/).
// PARAMETERS
//  SCAN_DIV      16      clk cycles each column is driven before rows are sampled; must be >= 4
//  DEBOUNCE_CNT  50000   consecutive stable cycles needed to accept a press or a release
//  REPEAT_CYC    500000  cycles a key must be held before auto-repeat; used only with KEYPAD_AUTOREPEAT_EN
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  row_in       in   4  keypad rows, active-low (external pull-ups); asynchronous to clk
//  col_out      out  4  keypad column drive, active-low; exactly one bit low at any time
//  key_pressed  out  1  high while a debounced key is held
//  keypad_out   out  4  code of the last accepted key; stable whenever key_pressed is high
// BEHAVIOUR
//  - One clock: clk. Reset is asynchronous and active-high (rst).
//  - Reset values: col_out=4'b1110, key_pressed=0, keypad_out=4'h0, row synchroniser=4'hF, state=SCAN,
//    all counters=0. Asserting rst mid-press drops key_pressed at once; no event is produced on exit.
//  - row_in passes through a 2-flop synchroniser; all decisions below use the synchronised value rows_s.
//  - Row "one-hot-low" means exactly one bit of rows_s is 0.
//  - SCAN:
//    - col_out = ~(4'b1 << col_idx). dwell counts 0..SCAN_DIV-1.
//    - At dwell==SCAN_DIV-1, rows_s is checked. One-hot-low: latch row_idx and col_idx, clear cnt,
//      go to DEBOUNCE. Otherwise col_idx increments (3 wraps to 0) and dwell resets.
//    - Zero rows low or two or more rows low is "no key".
//  - DEBOUNCE:
//    - Column is frozen. cnt increments each cycle rows_s equals the latched pattern.
//    - Any mismatch: back to SCAN on the same column, dwell=0.
//    - cnt==DEBOUNCE_CNT-1: on that edge keypad_out<=decode(row,col), key_pressed<=1, go to PRESSED.
//  - PRESSED:
//    - key_pressed=1. Other keys are ignored (column frozen, extra rows low are ignored).
//    - Latched row going high: cnt=0, go to RELEASE.
//  - RELEASE:
//    - cnt increments while the latched row stays high.
//    - Latched row low again: back to PRESSED. key_pressed never dropped, so there is no new event.
//    - cnt==DEBOUNCE_CNT-1: key_pressed<=0, col_idx advances, go to SCAN.
//  - keypad_out is updated only on acceptance and holds its value after release.
//  - Press latency: SCAN_DIV remainder + 2 (sync) + DEBOUNCE_CNT cycles.
//  - Release latency: 2 + DEBOUNCE_CNT cycles.
//  - Minimum low time of key_pressed between events is DEBOUNCE_CNT + SCAN_DIV cycles. This is well above
//    the calculator's return-to-read time.
//  - Counters saturate and never wrap. Widths: dwell = $clog2(SCAN_DIV), cnt = $clog2(max(DEBOUNCE_CNT,REPEAT_CYC)).
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined:
//    - A hold counter runs in PRESSED and counts up to REPEAT_CYC-1.
//    - When it reaches REPEAT_CYC-1: key_pressed<=0 for exactly 8 cycles (REPEAT_GAP, still in PRESSED),
//      then key_pressed<=1 again with keypad_out unchanged. The hold counter restarts.
//    - Releasing during the gap goes to RELEASE normally; key_pressed stays 0.
//    - Code 4'hE (clear) never repeats.
//  KEYPAD_AUTOREPEAT_EN undefined:
//    - No hold counter is built. One event per physical press regardless of hold time.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CYC=40)
//  1. Hold row1 low while col2 is driven -> key_pressed rises <= 14 cycles later, keypad_out=4'h6.
//     Release -> key_pressed falls 10 cycles later.
//  2. Row0/col0 toggles every 3 cycles for 30 cycles, then stays low -> exactly one rising edge,
//     keypad_out=4'h1.
//  3. Rows 0 and 2 low together on col1 -> key_pressed stays 0 and col_out keeps cycling
//     1110->1101->1011->0111->1110.
//  4. Press r3c0, r3c2, r3c3 in turn -> keypad_out=4'hF, 4'hE, 4'hD, one rising edge each.
//  5. Assert rst while key_pressed=1 -> key_pressed=0 and col_out=4'b1110 before the next clk edge.
//     Key still held after rst falls -> one new event after debounce.
//  6. KEYPAD_AUTOREPEAT_EN, hold '5' -> key_pressed: 40 cycles high, 8 low, high again, keypad_out=4'h5.
//     Holding 'E' -> single event.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchroniser and press/release debounce.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 50000,
    parameter int unsigned REPEAT_CYC   = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_pressed,
    output logic [3:0] keypad_out
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CNT > REPEAT_CYC) ? DEBOUNCE_CNT : REPEAT_CYC;
    localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned GAP_W      = 3;
    localparam int unsigned REPEAT_GAP = 8;
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic               key_pressed_d;
    logic [3:0]         keypad_out_d;
    logic [3:0]         rows_s1, rows_s;
    logic [3:0]         row_pat;
    logic               row_hit;
    logic [1:0]         row_hit_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CNT_W-1:0]   hold_q, hold_d, hold_inc;
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hF;
            4'hD: code = 4'h0;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1 <= 4'hF;
            rows_s  <= 4'hF;
        end else begin
            rows_s1 <= row_in;
            rows_s  <= rows_s1;
        end
    end

    always_comb begin
        row_hit     = 1'b1;
        row_hit_idx = 2'd0;
        case (rows_s)
            4'b1110: row_hit_idx = 2'd0;
            4'b1101: row_hit_idx = 2'd1;
            4'b1011: row_hit_idx = 2'd2;
            4'b0111: row_hit_idx = 2'd3;
            default: row_hit     = 1'b0;
        endcase
    end

    assign row_pat   = ~(4'b0001 << row_idx_q);
    assign dwell_inc = (dwell_q == {DWELL_W{1'b1}}) ? dwell_q : dwell_q + DWELL_W'(1);
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    assign hold_inc  = (hold_q == {CNT_W{1'b1}}) ? hold_q : hold_q + CNT_W'(1);
`endif

    // Next-state and output logic; debounce thresholds act on the edge the count reaches them
    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        cnt_d         = cnt_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        key_pressed_d = key_pressed;
        keypad_out_d  = keypad_out;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_d        = hold_q;
        gap_d         = gap_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (row_hit) begin
                        row_idx_d = row_hit_idx;
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_inc;
                end
            end
            DEBOUNCE: begin
                if (rows_s == row_pat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        keypad_out_d  = decode(row_idx_q, col_idx_q);
                        key_pressed_d = 1'b1;
                        cnt_d         = '0;
                        state_d       = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        hold_d        = '0;
                        gap_d         = '0;
`endif
                    end
                end else begin
                    dwell_d = '0;
                    state_d = SCAN;
                end
            end
            PRESSED: begin
                if (rows_s[row_idx_q]) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (!key_pressed) begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_q == GAP_W'(REPEAT_GAP - 1)) begin
                        key_pressed_d = 1'b1;
                        hold_d        = '0;
                        gap_d         = '0;
                    end
                end else if (keypad_out != 4'hE) begin
                    if (hold_q == CNT_W'(REPEAT_CYC - 1)) begin
                        key_pressed_d = 1'b0;
                        hold_d        = '0;
                        gap_d         = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
`endif
            end
            RELEASE: begin
                if (!rows_s[row_idx_q]) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                    gap_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        key_pressed_d = 1'b0;
                        col_idx_d     = col_idx_q + 2'd1;
                        dwell_d       = '0;
                        cnt_d         = '0;
                        state_d       = SCAN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            col_out     <= 4'b1110;
            key_pressed <= 1'b0;
            keypad_out  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_q      <= '0;
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            col_out     <= ~(4'b0001 << col_idx_d);
            key_pressed <= key_pressed_d;
            keypad_out  <= keypad_out_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_q      <= hold_d;
            gap_q       <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple key-matrix model driving row_in from col_out.
// Auto-repeat checks are compiled only when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 8;
    localparam int unsigned REPEAT_CYC   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_pressed;
    logic [3:0]  keypad_out;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int rises  = 0;

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_CYC  (REPEAT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_pressed(key_pressed),
        .keypad_out (keypad_out)
    );

    always #5 clk = ~clk;

    // Key matrix: key (r,c) = keys[4*r+c]; a pressed key pulls its row low while its column is driven
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
    end

    always @(posedge key_pressed) rises++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_kp(input string tag, input logic val, input int budget, output int lat);
        lat = 0;
        while (key_pressed !== val && lat < budget) begin
            step(1);
            lat++;
        end
        check({tag, "_in_time"}, 32'(key_pressed === val), 32'd1);
    endtask

    initial begin
        int lat;
        int r0;
        int changes;
        logic kp_seen;
        logic [3:0] prev_col;
        logic [3:0] exp_col;

        keys = 16'h0;
        rst  = 1'b1;
        step(3);
        check("rst_col_out", 32'(col_out), 32'h0000000E);
        check("rst_key_pressed", 32'(key_pressed), 32'd0);
        check("rst_keypad_out", 32'(keypad_out), 32'd0);
        rst = 1'b0;

        // 1: key '6' (r1,c2) pressed just as column 2 becomes active
        prev_col = col_out;
        lat = 0;
        while (!(col_out == 4'b1011 && prev_col != 4'b1011) && lat < 40) begin
            prev_col = col_out;
            step(1);
            lat++;
        end
        check("t1_col2_seen", 32'(col_out), 32'h0000000B);
        keys[4*1+2] = 1'b1;
        wait_kp("t1_rise", 1'b1, 40, lat);
        check("t1_rise_lat_le14", 32'(lat <= 14), 32'd1);
        check("t1_rise_lat_ge_deb", 32'(lat >= int'(DEBOUNCE_CNT)), 32'd1);
        check("t1_code", 32'(keypad_out), 32'h6);
        check("t1_col_frozen", 32'(col_out), 32'h0000000B);
        keys = 16'h0;
        wait_kp("t1_fall", 1'b0, 40, lat);
        check("t1_fall_lat", 32'(lat), 32'd10);
        check("t1_code_held", 32'(keypad_out), 32'h6);

        // 2: key '1' bounces every 3 cycles for 30 cycles, then held
        r0 = rises;
        for (int i = 0; i < 10; i++) begin
            keys[0] = ~keys[0];
            step(3);
        end
        check("t2_no_event_bouncing", 32'(rises - r0), 32'd0);
        keys[0] = 1'b1;
        wait_kp("t2_rise", 1'b1, 60, lat);
        check("t2_code", 32'(keypad_out), 32'h1);
        step(20);
        check("t2_one_rise", 32'(rises - r0), 32'd1);
        check("t2_still_held", 32'(key_pressed), 32'd1);
        keys = 16'h0;
        wait_kp("t2_fall", 1'b0, 40, lat);

        // 3: two rows low on column 1 is no key; scanning keeps rotating
        keys = 16'h0;
        keys[4*0+1] = 1'b1;
        keys[4*2+1] = 1'b1;
        kp_seen  = 1'b0;
        changes  = 0;
        prev_col = col_out;
        for (int i = 0; i < 40; i++) begin
            step(1);
            kp_seen = kp_seen | key_pressed;
            if (col_out != prev_col) begin
                exp_col = {prev_col[2:0], prev_col[3]};
                check("t3_col_seq", 32'(col_out), 32'(exp_col));
                changes++;
                prev_col = col_out;
            end
        end
        check("t3_no_press", 32'(kp_seen), 32'd0);
        check("t3_col_changes", 32'(changes >= 9), 32'd1);
        keys = 16'h0;

        // 4: row 3 keys F, E, D in turn
        for (int k = 0; k < 3; k++) begin
            logic [3:0] exp_code;
            int bitn;
            bitn     = (k == 0) ? 12 : (k == 1) ? 14 : 15;
            exp_code = (k == 0) ? 4'hF : (k == 1) ? 4'hE : 4'hD;
            r0 = rises;
            keys[bitn] = 1'b1;
            wait_kp("t4_rise", 1'b1, 60, lat);
            check("t4_code", 32'(keypad_out), 32'(exp_code));
            keys = 16'h0;
            wait_kp("t4_fall", 1'b0, 40, lat);
            check("t4_one_rise", 32'(rises - r0), 32'd1);
        end

        // 5: reset while '7' is held, key stays held afterwards
        keys[4*2+0] = 1'b1;
        wait_kp("t5_rise", 1'b1, 60, lat);
        check("t5_code", 32'(keypad_out), 32'h7);
        rst = 1'b1;
        #1;
        check("t5_rst_kp", 32'(key_pressed), 32'd0);
        check("t5_rst_col", 32'(col_out), 32'h0000000E);
        check("t5_rst_code", 32'(keypad_out), 32'd0);
        step(1);
        rst = 1'b0;
        r0 = rises;
        wait_kp("t5_rerise", 1'b1, 60, lat);
        check("t5_recode", 32'(keypad_out), 32'h7);
        step(5);
        check("t5_one_rise", 32'(rises - r0), 32'd1);
        keys = 16'h0;
        wait_kp("t5_fall", 1'b0, 40, lat);

`ifdef KEYPAD_AUTOREPEAT_EN
        // 6: auto-repeat on '5', none on 'E'
        keys[4*1+1] = 1'b1;
        wait_kp("t6_rise", 1'b1, 60, lat);
        wait_kp("t6_gap_start", 1'b0, 60, lat);
        check("t6_high_len", 32'(lat), 32'(REPEAT_CYC));
        wait_kp("t6_gap_end", 1'b1, 20, lat);
        check("t6_gap_len", 32'(lat), 32'd8);
        check("t6_code", 32'(keypad_out), 32'h5);
        keys = 16'h0;
        wait_kp("t6_fall", 1'b0, 40, lat);
        r0 = rises;
        keys[4*3+2] = 1'b1;
        wait_kp("t6e_rise", 1'b1, 60, lat);
        step(100);
        check("t6e_held", 32'(key_pressed), 32'd1);
        check("t6e_one_rise", 32'(rises - r0), 32'd1);
        keys = 16'h0;
        wait_kp("t6e_fall", 1'b0, 40, lat);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
